os2ip: RTL and testbench
========================

OS2IP -- requirements
Module: os2ip

Interface
REQ-001: Parameter WIDTH, default 2048, is the bit width of the octet string and of the integer; it SHALL be a multiple of 8.
REQ-002: Parameter BPC, default 8, is the octets processed per clock; it SHALL divide WIDTH/8; N = WIDTH/(8*BPC) is the processing cycle count.
REQ-003: clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004: reset  input  1  SHALL be asynchronous and active-high.
REQ-005: ready  input  1  is the start request, level-sensitive; X SHALL be stable when ready is sampled high.
REQ-006: X  input  WIDTH  is the octet string; octet i occupies X[8i+7:8i], and octet 0 is the first (most significant) octet.
REQ-007: valid  output  1  SHALL be high while x holds a completed result.
REQ-008: x  output  WIDTH  is the integer result of OS2IP(X).

Function
REQ-009: x SHALL equal the octet-reversal of X over WIDTH/8 octets: x[WIDTH-1-8i -: 8] = X[8i+7:8i] for every i.
REQ-010: The FSM SHALL have states IDLE, BUSY and DONE.
REQ-011: In IDLE with ready=1 at a clock edge, the block SHALL:
  - capture X into an internal shift register src;
  - clear the accumulator acc and the cycle counter;
  - enter BUSY.
REQ-012: In IDLE with ready=0, the FSM SHALL stay in IDLE and x SHALL hold its last value.
REQ-013: Each BUSY cycle SHALL perform acc <= (acc << 8*BPC) | chunk, where chunk is src[8*BPC-1:0] octet-reversed (octet at src[7:0] placed most significant in chunk).
REQ-014: Each BUSY cycle SHALL also perform src <= src >> 8*BPC and increment the counter.
REQ-015: After the Nth BUSY cycle, the block SHALL load x with the final acc and enter DONE with valid=1.
REQ-016: Latency: valid SHALL rise on the (N+1)th rising edge after the edge that sampled ready high in IDLE.
REQ-017: ready changes during BUSY SHALL be ignored; the conversion always completes.
REQ-018: In DONE, valid=1 and x SHALL be held while ready=1.
REQ-019: In DONE, ready=0 at an edge SHALL return the FSM to IDLE with valid=0 and x retained.
REQ-020: X changes after capture SHALL NOT affect the result in progress.
REQ-021: valid SHALL be registered and glitch-free; x SHALL change only when valid rises.

Reset
REQ-022: While reset=1, the block SHALL immediately force: state IDLE, valid=0, x=0, src=0, acc=0, counter=0.
REQ-023: Reset asserted during BUSY or DONE SHALL abort the conversion; no valid pulse SHALL follow.
REQ-024: After reset deasserts, the first edge with ready=1 SHALL start a fresh conversion.

Verification
REQ-025: WIDTH=32, BPC=1, X=0x04030201, ready held high -> x=0x01020304, valid=1 at the 5th edge after the start edge, and held.
REQ-026: WIDTH=2048, BPC=8, reset pulse, then X=0x04030201 with ready=1 -> valid rises 33 cycles later; x = 0x01020304 in bits [2047:2016], all other bits 0.
REQ-027: WIDTH=32, BPC=2, X=0xAABBCCDD, ready pulsed for 1 cycle -> x=0xDDCCBBAA; valid high 1 cycle (DONE exits on ready=0), then IDLE with x retained.
REQ-028: Reset asserted mid-BUSY -> valid=0 and x=0 immediately; no completion afterward until ready is re-asserted.
REQ-029: X changed to 0xFFFFFFFF during BUSY (WIDTH=32, BPC=1, original X=0x04030201) -> result remains 0x01020304.
REQ-030: Back-to-back conversions: ready dropped in DONE, then re-asserted with X=0x00000080 (WIDTH=32, BPC=1) -> x=0x80000000 after a further 5 edges.

Source files
------------

// File: rtl/os2ip.sv
// OS2IP: converts an octet string to an integer by reversing its octets.
// Processes BPC octets per clock through a shift register and accumulator.
module os2ip #(
    parameter int WIDTH = 2048,
    parameter int BPC   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [WIDTH-1:0] X,
    output logic             valid,
    output logic [WIDTH-1:0] x
);

    localparam int CB = 8 * BPC;
    localparam int N  = WIDTH / CB;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] acc;
    logic [CB-1:0]    chunk;
    logic [CW-1:0]    cnt;
    logic             last;

    // Counter reaching N means every chunk is already in acc.
    assign last = (cnt == LAST);

    // Low BPC octets of src, reversed so src[7:0] lands most significant.
    always_comb begin
        chunk = '0;
        for (int j = 0; j < BPC; j++) begin
            chunk[CB-1-8*j -: 8] = src[8*j +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; ready is ignored while a conversion runs.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (ready) state_nx = BUSY;
            BUSY: if (last) state_nx = DONE;
            DONE: if (!ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture, shift/accumulate, then publish result once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src   <= '0;
            acc   <= '0;
            cnt   <= '0;
            x     <= '0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ready) begin
                        src <= X;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!last) begin
                        acc <= (acc << CB) | WIDTH'(chunk);
                        src <= src >> CB;
                        cnt <= cnt + CW'(1);
                    end else begin
                        x     <= acc;
                        valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!ready) valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_os2ip.sv
// Scoreboard bench for os2ip across three WIDTH/BPC configurations.
// Drivers push expected results; a negedge monitor checks each valid rise.
module tb_os2ip;

    typedef struct {
        logic [2047:0] d;
        int            e;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic          rst0, rst1, rst2;
    logic          rdy0, rdy1, rdy2;
    logic [31:0]   xi0, xi2;
    logic [2047:0] xi1;
    logic          v0, v1, v2;
    logic          v0_q = 1'b0, v1_q = 1'b0, v2_q = 1'b0;
    logic [31:0]   xo0, xo2;
    logic [2047:0] xo1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    os2ip #(.WIDTH(32), .BPC(1)) u0 (
        .clk(clk), .reset(rst0), .ready(rdy0),
        .X(xi0), .valid(v0), .x(xo0)
    );

    os2ip #(.WIDTH(2048), .BPC(8)) u1 (
        .clk(clk), .reset(rst1), .ready(rdy1),
        .X(xi1), .valid(v1), .x(xo1)
    );

    os2ip #(.WIDTH(32), .BPC(2)) u2 (
        .clk(clk), .reset(rst2), .ready(rdy2),
        .X(xi2), .valid(v2), .x(xo2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act,
                                logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    function automatic void miss(string nm);
        checks++;
        errors++;
        $display("FAIL %s: valid rose with no expected result", nm);
    endfunction

    // Monitor: compare result and latency on every valid rise.
    always @(negedge clk) begin
        exp_t e;
        if (v0 && !v0_q) begin
            if (q0.size() == 0) miss("u0_unexpected");
            else begin
                e = q0.pop_front();
                chk("u0_x", 64'(xo0), 64'(e.d[31:0]));
                chk("u0_lat", 64'(cyc), 64'(e.e));
            end
        end
        if (v1 && !v1_q) begin
            if (q1.size() == 0) miss("u1_unexpected");
            else begin
                e = q1.pop_front();
                chk("u1_x_top", xo1[2047:1984], e.d[2047:1984]);
                chk("u1_x_rest", 64'(xo1[1983:0] != e.d[1983:0]), 64'd0);
                chk("u1_lat", 64'(cyc), 64'(e.e));
            end
        end
        if (v2 && !v2_q) begin
            if (q2.size() == 0) miss("u2_unexpected");
            else begin
                e = q2.pop_front();
                chk("u2_x", 64'(xo2), 64'(e.d[31:0]));
                chk("u2_lat", 64'(cyc), 64'(e.e));
            end
        end
        v0_q <= v0;
        v1_q <= v1;
        v2_q <= v2;
    end

    task automatic waitn(int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected valid-rise edge: start edge is cyc+1, plus N+1 edges.
    task automatic push(int inst, logic [2047:0] d, int n);
        exp_t e;
        e.d = d;
        e.e = cyc + n + 2;
        case (inst)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    initial begin
        int cnt;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
        xi0 = '0; xi1 = '0; xi2 = '0;
        waitn(2);
        chk("rst_v0", 64'(v0), 64'd0);
        chk("rst_x0", 64'(xo0), 64'd0);
        chk("rst_v1", 64'(v1), 64'd0);
        chk("rst_x1", 64'(xo1 != '0), 64'd0);
        chk("rst_v2", 64'(v2), 64'd0);
        chk("rst_x2", 64'(xo2), 64'd0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        waitn(1);

        // Ready held high; X disturbed right after capture.
        xi0 = 32'h04030201;
        rdy0 = 1'b1;
        push(0, 2048'h01020304, 4);
        waitn(1);
        xi0 = 32'hFFFFFFFF;
        waitn(8);
        chk("hold_v0", 64'(v0), 64'd1);
        chk("hold_x0", 64'(xo0), 64'h01020304);
        rdy0 = 1'b0;
        waitn(1);
        chk("idle_v0", 64'(v0), 64'd0);
        chk("idle_x0", 64'(xo0), 64'h01020304);

        // Back-to-back with a one-cycle ready pulse.
        xi0 = 32'h00000080;
        rdy0 = 1'b1;
        push(0, 2048'h80000000, 4);
        waitn(1);
        rdy0 = 1'b0;
        waitn(8);
        chk("b2b_v0", 64'(v0), 64'd0);
        chk("b2b_x0", 64'(xo0), 64'h80000000);

        // BPC=2, single-cycle ready: valid high for exactly one cycle.
        xi2 = 32'hAABBCCDD;
        rdy2 = 1'b1;
        push(2, 2048'hDDCCBBAA, 2);
        waitn(1);
        rdy2 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            waitn(1);
            if (v2) cnt++;
        end
        chk("u2_vcount", 64'(cnt), 64'd1);
        chk("u2_retain", 64'(xo2), 64'hDDCCBBAA);

        // Wide configuration after a reset pulse.
        rst1 = 1'b1;
        waitn(1);
        rst1 = 1'b0;
        xi1 = 2048'h04030201;
        rdy1 = 1'b1;
        push(1, 2048'h01020304 << 2016, 32);
        waitn(36);
        chk("u1_hold", 64'(v1), 64'd1);
        rdy1 = 1'b0;
        waitn(2);

        // Reset mid-conversion aborts with no later valid.
        xi0 = 32'h04030201;
        rdy0 = 1'b1;
        waitn(1);
        rdy0 = 1'b0;
        waitn(1);
        rst0 = 1'b1;
        #1;
        chk("abort_v0", 64'(v0), 64'd0);
        chk("abort_x0", 64'(xo0), 64'd0);
        waitn(1);
        rst0 = 1'b0;
        waitn(10);
        chk("abort_quiet_v0", 64'(v0), 64'd0);
        chk("abort_quiet_x0", 64'(xo0), 64'd0);

        // Fresh conversion after reset.
        xi0 = 32'h11223344;
        rdy0 = 1'b1;
        push(0, 2048'h44332211, 4);
        waitn(1);
        rdy0 = 1'b0;
        waitn(8);
        chk("fresh_x0", 64'(xo0), 64'h44332211);

        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);
        chk("q2_empty", 64'(q2.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
